ma_wb_pipe_stage: RTL

- Parametrised elastic pipeline register for the memory-access / write-back boundary of the SimpleRisc pipeline.
- Carries an opaque stage payload (instruction, ALU result, load result, control flags) plus a destination register and write-back flag through a 2-entry (main + skid) buffer.
- Supports valid/ready handshaking, flush-to-bubble and stall/bubble performance counters.
- Replaces fixed, always-latching stage registers with explicit port-driven handshakes so upstream and downstream stages can stall independently.

---
 rtl/ma_wb_pipe_stage.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ma_wb_pipe_stage.sv
// ma_wb_pipe_stage: elastic MA/WB pipeline register with a main + skid entry, flush, and bubble/stall counters
//
// Ports (all state updates on the falling edge of Clk):
//   Clk, Reset_n               stage clock, asynchronous active-low reset
//   In_Valid/In_Ready          upstream handshake; In_Ready is registered (no path from Out_Ready)
//   In_Data/In_Rd/In_IsWb      incoming token payload, destination register, write-back flag
//   Flush                      drop every held token and any token offered on the same edge
//   Out_Valid/Out_Ready        downstream handshake, driven from the main entry
//   Out_Data/Out_Rd/Out_IsWb   head token; Out_IsWb is 0 whenever Out_Valid is 0
//   Bubble_Count/Stall_Count   saturating counters of empty and back-pressured edges
module ma_wb_pipe_stage #(
    parameter int DATA_W = 128,
    parameter int RD_W   = 4,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [DATA_W-1:0] In_Data,
    input  logic [RD_W-1:0]   In_Rd,
    input  logic              In_IsWb,
    input  logic              Flush,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [DATA_W-1:0] Out_Data,
    output logic [RD_W-1:0]   Out_Rd,
    output logic              Out_IsWb,
    output logic [CNT_W-1:0]  Bubble_Count,
    output logic [CNT_W-1:0]  Stall_Count
);
    logic              m_valid_q, m_valid_d, s_valid_q, s_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
    logic [RD_W-1:0]   m_rd_q, m_rd_d, s_rd_q, s_rd_d;
    logic              m_iswb_q, m_iswb_d, s_iswb_q, s_iswb_d;
    logic              in_ready_q, in_ready_d, out_iswb_q, out_iswb_d;
    logic [CNT_W-1:0]  bubble_q, bubble_d, stall_q, stall_d;
    logic              accept, pop;

    assign accept = In_Valid & in_ready_q;
    assign pop    = m_valid_q & Out_Ready;

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_rd_d    = m_rd_q;
        m_iswb_d  = m_iswb_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        s_rd_d    = s_rd_q;
        s_iswb_d  = s_iswb_q;
        if (Flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!m_valid_q || pop) begin
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                m_data_d  = s_data_q;
                m_rd_d    = s_rd_q;
                m_iswb_d  = s_iswb_q;
                s_valid_d = accept;
                if (accept) begin
                    s_data_d = In_Data;
                    s_rd_d   = In_Rd;
                    s_iswb_d = In_IsWb;
                end
            end else begin
                m_valid_d = accept;
                if (accept) begin
                    m_data_d = In_Data;
                    m_rd_d   = In_Rd;
                    m_iswb_d = In_IsWb;
                end
            end
        end else if (accept) begin
            s_valid_d = 1'b1;
            s_data_d  = In_Data;
            s_rd_d    = In_Rd;
            s_iswb_d  = In_IsWb;
        end
        in_ready_d = ~s_valid_d;
        // write-enable is gated by the next valid so a flushed or drained head never writes back
        out_iswb_d = m_iswb_d & m_valid_d;
        bubble_d   = (!m_valid_q && bubble_q != {CNT_W{1'b1}}) ? bubble_q + 1'b1 : bubble_q;
        stall_d    = (m_valid_q && !Out_Ready && stall_q != {CNT_W{1'b1}}) ? stall_q + 1'b1 : stall_q;
    end

    always_ff @(negedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_rd_q     <= '0;
            m_iswb_q   <= 1'b0;
            s_valid_q  <= 1'b0;
            s_data_q   <= '0;
            s_rd_q     <= '0;
            s_iswb_q   <= 1'b0;
            in_ready_q <= 1'b1;
            out_iswb_q <= 1'b0;
            bubble_q   <= '0;
            stall_q    <= '0;
        end else begin
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_rd_q     <= m_rd_d;
            m_iswb_q   <= m_iswb_d;
            s_valid_q  <= s_valid_d;
            s_data_q   <= s_data_d;
            s_rd_q     <= s_rd_d;
            s_iswb_q   <= s_iswb_d;
            in_ready_q <= in_ready_d;
            out_iswb_q <= out_iswb_d;
            bubble_q   <= bubble_d;
            stall_q    <= stall_d;
        end
    end

    assign In_Ready     = in_ready_q;
    assign Out_Valid    = m_valid_q;
    assign Out_Data     = m_data_q;
    assign Out_Rd       = m_rd_q;
    assign Out_IsWb     = out_iswb_q;
    assign Bubble_Count = bubble_q;
    assign Stall_Count  = stall_q;
endmodule
